// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control encoding and the multiply/divide unit types.
package cpu_pkg;

  typedef enum logic [4:0] {
    ALU_MULT  = 5'b10000,
    ALU_MULTU = 5'b10001,
    ALU_DIV   = 5'b10010,
    ALU_DIVU  = 5'b10011,
    ALU_MTLO  = 5'b10101,
    ALU_MTHI  = 5'b10110
  } alu_control_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } muldiv_state_t;

  typedef enum logic {
    CORE_MUL,
    CORE_DIV
  } core_mode_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// One unsigned radix-2 step: shift-add multiply or restoring divide.
module muldiv_iter_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  core_mode_t         mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_next = '0;
    q_bit    = 1'b0;
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & operand};
    trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    if (mode == CORE_MUL) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      // The freed quotient slot is left 0; the caller merges q_bit into it.
      q_bit    = ~trial[WIDTH];
      acc_next = q_bit ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                       : {acc[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO writes.
module hilo_muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  muldiv_state_t      state, state_next;
  logic [CNT_W-1:0]   cnt;
  core_mode_t         mode;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   operand;
  logic               q_bit;
  logic               neg_lo, neg_hi, dz_pending;

  logic               md_start, mt_start, is_div, is_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag, quotient, remainder;
  logic [2*WIDTH-1:0] product;

  always_comb begin
    is_div    = (op == ALU_DIV)  || (op == ALU_DIVU);
    is_signed = (op == ALU_MULT) || (op == ALU_DIV);
    md_start  = start && (is_div || op == ALU_MULT || op == ALU_MULTU);
    mt_start  = start && (op == ALU_MTHI || op == ALU_MTLO);
    rs_neg    = is_signed && rs_data[WIDTH-1];
    rt_neg    = is_signed && rt_data[WIDTH-1];
    rs_mag    = rs_neg ? -rs_data : rs_data;
    rt_mag    = rt_neg ? -rt_data : rt_data;
    product   = neg_lo ? -acc : acc;
    quotient  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remainder = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .mode     (mode),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_next = state;
    case (state)
      MD_RUN:  if (cnt == LAST_STEP) state_next = MD_FIX;
      MD_FIX:  state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    // Any new issue aborts whatever is in flight.
    if (md_start)      state_next = MD_RUN;
    else if (mt_start) state_next = MD_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= MD_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      mode        <= CORE_MUL;
      acc         <= '0;
      operand     <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      dz_pending  <= 1'b0;
    end else begin
      state       <= state_next;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (md_start) begin
        busy       <= 1'b1;
        cnt        <= '0;
        mode       <= is_div ? CORE_DIV : CORE_MUL;
        acc        <= {{WIDTH{1'b0}}, (is_div ? rs_mag : rt_mag)};
        operand    <= is_div ? rt_mag : rs_mag;
        neg_lo     <= rs_neg ^ rt_neg;
        neg_hi     <= rs_neg;
        dz_pending <= is_div && (rt_data == '0);
      end else if (mt_start) begin
        busy <= 1'b0;
        if (op == ALU_MTHI) hi <= rs_data;
        else                lo <= rs_data;
      end else begin
        case (state)
          MD_RUN: begin
            acc <= acc_next | {{(2*WIDTH-1){1'b0}}, q_bit};
            cnt <= cnt + CNT_W'(1);
          end
          MD_FIX: begin
            busy <= 1'b0;
            done <= 1'b1;
            if (dz_pending) begin
              div_by_zero <= 1'b1;
            end else if (mode == CORE_MUL) begin
              {hi, lo} <= product;
            end else begin
              lo <= quotient;
              hi <= remainder;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
